dis_sched: RTL and testbench

Dispatch scheduler for the RR/DIS pipeline register. It inspects the two instructions held at the DIS side of that register and decides whether the pair can be written into the four reservation stations. It tracks per-station occupancy with credit counters and asserts `stall` to freeze the RR/DIS register when the pair does not fit. It also clears all occupancy on branch-recover.

---
 rtl/dis_sched.sv | 133 +++++++++++++
 tb/tb_dis_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dis_sched.sv
// Dispatch scheduler: all-or-nothing pair dispatch into four credit-tracked reservation stations.
// Optional stall counter output enabled by defining DIS_STALL_CNT_EN.
module dis_sched #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            recover,
  input  logic            valid1dis,
  input  logic            res_en1dis,
  input  logic [1:0]      resnum1dis,
  input  logic            valid2dis,
  input  logic            res_en2dis,
  input  logic [1:0]      resnum2dis,
  input  logic [3:0]      rs_release,
  output logic            dis_we1,
  output logic            dis_we2,
  output logic            stall,
  output logic [4*CW-1:0] rs_occ,
  output logic            credit_err
`ifdef DIS_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {StRun, StHold, StFlush} state_e;

  localparam logic [CW:0] DepthW = (CW+1)'(RS_DEPTH);

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_occ [4];
  logic [CW-1:0] w_occ_next [4];
  logic [1:0]    w_dem [4];
  logic          r_err;
  logic          w_err_set;
  logic          w_need1, w_need2;
  logic          w_fits, w_dispatch;
  logic          w_we1, w_we2, w_stall;

  assign w_need1 = valid1dis & res_en1dis;
  assign w_need2 = valid2dis & res_en2dis;

  // Fit check uses registered occupancy only; same-cycle releases count next cycle.
  always_comb begin
    w_fits = 1'b1;
    for (int s = 0; s < 4; s++) begin
      w_dem[s] = {1'b0, w_need1 & (resnum1dis == 2'(s))} +
                 {1'b0, w_need2 & (resnum2dis == 2'(s))};
      if (({1'b0, r_occ[s]} + (CW+1)'(w_dem[s])) > DepthW) w_fits = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_we1        = 1'b0;
    w_we2        = 1'b0;
    w_stall      = 1'b0;
    w_dispatch   = 1'b0;
    if (recover) begin
      w_state_next = StFlush;
    end else begin
      unique case (r_state)
        StFlush: w_state_next = StRun;
        StRun, StHold: begin
          if (w_fits) begin
            w_dispatch   = 1'b1;
            w_we1        = w_need1;
            w_we2        = w_need2;
            w_state_next = StRun;
          end else begin
            w_stall      = 1'b1;
            w_state_next = StHold;
          end
        end
        default: w_state_next = StRun;
      endcase
    end
  end

  // Releases are ignored while recovering or flushing; release on an empty station saturates.
  always_comb begin
    w_err_set = 1'b0;
    for (int s = 0; s < 4; s++) begin
      w_occ_next[s] = r_occ[s];
      if (recover) begin
        w_occ_next[s] = '0;
      end else if (r_state != StFlush) begin
        if (w_dispatch) w_occ_next[s] = w_occ_next[s] + CW'(w_dem[s]);
        if (rs_release[s]) begin
          if (r_occ[s] == '0) w_err_set = 1'b1;
          else                w_occ_next[s] = w_occ_next[s] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StRun;
      r_err   <= 1'b0;
      for (int s = 0; s < 4; s++) r_occ[s] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_err_set) r_err <= 1'b1;
      for (int s = 0; s < 4; s++) r_occ[s] <= w_occ_next[s];
    end
  end

  // Gate with reset so outputs drop asynchronously, even mid-HOLD.
  assign dis_we1    = w_we1 & rst;
  assign dis_we2    = w_we2 & rst;
  assign stall      = w_stall & rst;
  assign credit_err = r_err;

  always_comb begin
    rs_occ = '0;
    for (int s = 0; s < 4; s++) rs_occ[s*CW +: CW] = r_occ[s];
  end

`ifdef DIS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_stall_cnt <= '0;
    else if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dis_sched.sv
// Self-checking bench for dis_sched: directed scenarios then randomized traffic vs a credit model.
module tb_dis_sched;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            recover;
  logic            valid1dis, res_en1dis, valid2dis, res_en2dis;
  logic [1:0]      resnum1dis, resnum2dis;
  logic [3:0]      rs_release;
  logic            dis_we1, dis_we2, stall, credit_err;
  logic [4*CW-1:0] rs_occ;
`ifdef DIS_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  dis_sched #(.RS_DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .recover    (recover),
    .valid1dis  (valid1dis),
    .res_en1dis (res_en1dis),
    .resnum1dis (resnum1dis),
    .valid2dis  (valid2dis),
    .res_en2dis (res_en2dis),
    .resnum2dis (resnum2dis),
    .rs_release (rs_release),
    .dis_we1    (dis_we1),
    .dis_we2    (dis_we2),
    .stall      (stall),
    .rs_occ     (rs_occ),
    .credit_err (credit_err)
`ifdef DIS_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  // Reference model: per-station entry counts, a flush flag, the sticky error and stall count.
  int          m_occ [4];
  int          m_dem [4];
  bit          m_flush, m_err, m_disp;
  bit          e_we1, e_we2, e_stall;
  logic [31:0] m_scnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit n1, n2, fits;
    n1 = valid1dis & res_en1dis;
    n2 = valid2dis & res_en2dis;
    for (int s = 0; s < 4; s++) m_dem[s] = 0;
    if (n1) m_dem[resnum1dis]++;
    if (n2) m_dem[resnum2dis]++;
    fits = 1'b1;
    for (int s = 0; s < 4; s++) if (m_occ[s] + m_dem[s] > int'(DEPTH)) fits = 1'b0;
    e_we1 = 0; e_we2 = 0; e_stall = 0; m_disp = 0;
    if (rst && !recover && !m_flush) begin
      if (fits) begin
        e_we1 = n1; e_we2 = n2; m_disp = 1;
      end else begin
        e_stall = 1;
      end
    end
  endtask

  function automatic logic [4*CW-1:0] exp_occ();
    logic [4*CW-1:0] v;
    for (int s = 0; s < 4; s++) v[s*CW +: CW] = CW'(m_occ[s]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    predict();
    check({tag, ".we1"},   32'(dis_we1),    32'(e_we1));
    check({tag, ".we2"},   32'(dis_we2),    32'(e_we2));
    check({tag, ".stall"}, 32'(stall),      32'(e_stall));
    check({tag, ".occ"},   32'(rs_occ),     32'(exp_occ()));
    check({tag, ".err"},   32'(credit_err), 32'(m_err));
`ifdef DIS_STALL_CNT_EN
    check({tag, ".scnt"},  stall_cnt,       m_scnt);
`endif
  endtask

  // Called at a negedge with inputs set: check, clock once, advance the model.
  task automatic step(input string tag);
    int old;
    #1;
    check_all(tag);
    @(posedge clk);
    m_scnt = m_scnt + 32'(e_stall);
    if (recover) begin
      for (int s = 0; s < 4; s++) m_occ[s] = 0;
      m_flush = 1;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        old = m_occ[s];
        if (m_disp) m_occ[s] += m_dem[s];
        if (rs_release[s]) begin
          if (old == 0) m_err = 1;
          else          m_occ[s]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit v1, input bit e1, input int r1, input bit v2, input bit e2,
                        input int r2, input logic [3:0] rel, input bit rc);
    valid1dis = v1; res_en1dis = e1; resnum1dis = 2'(r1);
    valid2dis = v2; res_en2dis = e2; resnum2dis = 2'(r2);
    rs_release = rel; recover = rc;
  endtask

  // Asserted at a negedge; outputs are checked before any clock edge arrives.
  task automatic do_reset();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) m_occ[s] = 0;
    m_flush = 0; m_err = 0; m_scnt = '0;
    #1;
    check_all("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill_pairs(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1, 1, s, 1, 1, s, 4'b0000, 0);
      step("fill");
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) m_occ[s] = 0;
    m_flush = 0; m_err = 0; m_scnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Reset then one dispatch into station 2.
    set_in(1, 1, 2, 1, 1, 2, 4'b0000, 0);
    #1;
    check("disp.we1", 32'(dis_we1), 32'd1);
    check("disp.we2", 32'(dis_we2), 32'd1);
    step("disp");
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    #1;
    check("disp.occ2", 32'(rs_occ[11:8]), 32'd2);
    step("idle");

    // Station 1 to 7, then a pair that does not fit while a release is pulsed.
    fill_pairs(1, 3);
    set_in(1, 1, 1, 0, 0, 0, 4'b0000, 0);
    step("fill7");
    set_in(1, 1, 1, 1, 1, 1, 4'b0010, 0);
    #1;
    check("full.stall", 32'(stall), 32'd1);
    step("full");
    set_in(1, 1, 1, 1, 1, 1, 4'b0000, 0);
    #1;
    check("afterrel.stall", 32'(stall), 32'd0);
    step("afterrel");
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    #1;
    check("occ1.eight", 32'(rs_occ[7:4]), 32'd8);
    step("idle");

    // Recover in the middle of a HOLD on a full station 0.
    fill_pairs(0, 4);
    set_in(1, 1, 0, 1, 1, 0, 4'b0000, 0);
    step("hold");
    set_in(1, 1, 0, 1, 1, 0, 4'b0000, 1);
    #1;
    check("rec.stall", 32'(stall), 32'd0);
    step("rec");
    set_in(1, 1, 0, 1, 1, 0, 4'b1111, 0);
    #1;
    check("flush.occ", 32'(rs_occ), 32'd0);
    check("flush.we1", 32'(dis_we1), 32'd0);
    step("flush");
    step("run");

    // Underflow on empty station 3; error survives recover, clears on reset.
    set_in(0, 0, 0, 0, 0, 0, 4'b1000, 0);
    step("uflow");
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 1);
    #1;
    check("uflow.err", 32'(credit_err), 32'd1);
    step("uflow.rec");
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    step("uflow.flush");
    check("uflow.err2", 32'(credit_err), 32'd1);
    do_reset();
    check("uflow.clr", 32'(credit_err), 32'd0);

    // No-credit slot with every station full.
    for (int s = 0; s < 4; s++) fill_pairs(s, 4);
    set_in(1, 0, 2, 0, 0, 0, 4'b0000, 0);
    #1;
    check("nop.stall", 32'(stall), 32'd0);
    check("nop.we1", 32'(dis_we1), 32'd0);
    step("nop");
    check("nop.occ", 32'(rs_occ), 32'h8888);

    // Reset while stalled drops stall with no clock edge.
    set_in(1, 1, 3, 0, 0, 0, 4'b0000, 0);
    step("prerst");
    do_reset();

`ifdef DIS_STALL_CNT_EN
    fill_pairs(0, 4);
    set_in(1, 1, 0, 1, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step("scnt.hold");
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    step("scnt.idle");
    check("scnt.five", stall_cnt, 32'd5);
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 1);
    step("scnt.rec");
    check("scnt.keep", stall_cnt, 32'd5);
    set_in(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    step("scnt.flush");
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
             4'(($urandom_range(0, 9) < 3) | (($urandom_range(0, 9) < 3) << 1) |
                (($urandom_range(0, 9) < 3) << 2) | (($urandom_range(0, 9) < 3) << 3)),
             ($urandom_range(0, 39) == 0));
      step("rand");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
